// File: rtl/iob_eth_rx_param.sv
// iob_eth_rx_param: parametrised Ethernet MII/GMII receive engine.
// Hunts preamble/SFD, assembles bytes, filters on destination MAC, writes the
// frame into the RX buffer, checks the FCS and holds a frame-ready flag until
// the host acknowledges. Drops on RX_ER, buffer overflow or a busy buffer.
// Optional build macro IOB_ETH_RX_PROMISC_EN adds a 'promisc' input that
// bypasses the destination-MAC filter.
module iob_eth_rx_param #(
    parameter int          DATA_W   = 4,
    parameter int          ADDR_W   = 11,
    parameter logic [47:0] MAC_ADDR = 48'h000000000000
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              RX_DV,
    input  logic              RX_ER,
    input  logic [DATA_W-1:0] RX_DATA,
`ifdef IOB_ETH_RX_PROMISC_EN
    input  logic              promisc,
`endif
    output logic              rx_wr,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [7:0]        rx_wdata,
    output logic              frame_received,
    output logic [ADDR_W:0]   rx_len,
    input  logic              frame_ack,
    output logic              crc_err,
    output logic              frame_dropped
);

    localparam logic [31:0]     CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]     CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [ADDR_W:0] MIN_LEN     = (ADDR_W+1)'(64);
    localparam logic [ADDR_W:0] DEST_LAST   = (ADDR_W+1)'(5);
    localparam logic [ADDR_W:0] MAX_CNT     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {WAIT_IDLE, HUNT, DATA, CHECK, HOLD} state_t;

    state_t          state;
    logic [ADDR_W:0] cnt;
    logic [31:0]     crc;
    logic [3:0]      nib_lo;
    logic            half;
    logic            seen_pre;
    logic            uni_ok;
    logic            bc_ok;
    logic            hold_sfd;

    logic            is_pre;
    logic            is_sfd;
    logic            byte_done;
    logic [7:0]      lane_byte;
    logic            in_dest;
    logic            uni_nx;
    logic            bc_nx;
    logic            dest_ok;

    // One reflected CRC-32 step over a whole byte, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // The reflected register holds the residue in reversed bit order.
    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Destination-MAC byte for position idx, most significant byte first.
    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return MAC_ADDR[47:40];
            3'd1:    return MAC_ADDR[39:32];
            3'd2:    return MAC_ADDR[31:24];
            3'd3:    return MAC_ADDR[23:16];
            3'd4:    return MAC_ADDR[15:8];
            3'd5:    return MAC_ADDR[7:0];
            default: return 8'h00;
        endcase
    endfunction

    generate
        if (DATA_W == 8) begin : g_gmii
            assign is_pre    = (RX_DATA == 8'h55);
            assign is_sfd    = (RX_DATA == 8'hD5);
            assign byte_done = 1'b1;
            assign lane_byte = RX_DATA;
        end else begin : g_mii
            // MII: SFD nibble only counts after at least one preamble nibble.
            assign is_pre    = (RX_DATA == 4'h5);
            assign is_sfd    = (RX_DATA == 4'hD) && seen_pre;
            assign byte_done = half;
            assign lane_byte = {RX_DATA, nib_lo};
        end
    endgenerate

    // Running destination match for the byte currently completing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        in_dest = 1'b0;
        uni_nx  = uni_ok;
        bc_nx   = bc_ok;
        if (cnt <= DEST_LAST) begin
            in_dest = 1'b1;
            uni_nx  = uni_ok & (lane_byte == mac_byte(cnt[2:0]));
            bc_nx   = bc_ok & (lane_byte == 8'hFF);
        end
`ifdef IOB_ETH_RX_PROMISC_EN
        dest_ok = uni_nx | bc_nx | promisc;
`else
        dest_ok = uni_nx | bc_nx;
`endif
    end

    // Receive FSM with registered buffer-write, status and pulse outputs.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state          <= WAIT_IDLE;
            cnt            <= '0;
            crc            <= '0;
            nib_lo         <= '0;
            half           <= 1'b0;
            seen_pre       <= 1'b0;
            uni_ok         <= 1'b0;
            bc_ok          <= 1'b0;
            hold_sfd       <= 1'b0;
            rx_wr          <= 1'b0;
            rx_addr        <= '0;
            rx_wdata       <= '0;
            frame_received <= 1'b0;
            rx_len         <= '0;
            crc_err        <= 1'b0;
            frame_dropped  <= 1'b0;
        end else begin
            rx_wr         <= 1'b0;
            crc_err       <= 1'b0;
            frame_dropped <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    seen_pre <= 1'b0;
                    if (!RX_DV) state <= HUNT;
                end
                HUNT: begin
                    if (!RX_DV) begin
                        seen_pre <= 1'b0;
                    end else if (is_sfd) begin
                        state    <= DATA;
                        cnt      <= '0;
                        crc      <= 32'hFFFFFFFF;
                        half     <= 1'b0;
                        uni_ok   <= 1'b1;
                        bc_ok    <= 1'b1;
                        seen_pre <= 1'b0;
                    end else if (is_pre) begin
                        seen_pre <= 1'b1;
                    end else begin
                        state <= WAIT_IDLE;
                    end
                end
                DATA: begin
                    if (!RX_DV) begin
                        // A trailing half byte is simply never written.
                        state <= (cnt < MIN_LEN) ? HUNT : CHECK;
                    end else if (RX_ER) begin
                        frame_dropped <= 1'b1;
                        state         <= WAIT_IDLE;
                    end else begin
                        nib_lo <= RX_DATA[3:0];
                        half   <= ~half;
                        if (byte_done) begin
                            if (cnt == MAX_CNT) begin
                                frame_dropped <= 1'b1;
                                state         <= WAIT_IDLE;
                            end else begin
                                rx_wr    <= 1'b1;
                                rx_addr  <= cnt[ADDR_W-1:0];
                                rx_wdata <= lane_byte;
                                crc      <= crc_step(crc, lane_byte);
                                cnt      <= cnt + 1'b1;
                                if (in_dest) begin
                                    uni_ok <= uni_nx;
                                    bc_ok  <= bc_nx;
                                end
                                if (cnt == DEST_LAST && !dest_ok) state <= WAIT_IDLE;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (bit_rev(crc) == CRC_RESIDUE) begin
                        frame_received <= 1'b1;
                        rx_len         <= cnt;
                        hold_sfd       <= 1'b0;
                        seen_pre       <= 1'b0;
                        state          <= HOLD;
                    end else begin
                        crc_err <= 1'b1;
                        state   <= HUNT;
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        frame_received <= 1'b0;
                        seen_pre       <= 1'b0;
                        state          <= RX_DV ? WAIT_IDLE : HUNT;
                    end else if (RX_DV) begin
                        // Buffer busy: report each arriving frame once, at its SFD.
                        seen_pre <= is_pre;
                        if (is_sfd && !hold_sfd) begin
                            frame_dropped <= 1'b1;
                            hold_sfd      <= 1'b1;
                        end
                    end else begin
                        seen_pre <= 1'b0;
                        hold_sfd <= 1'b0;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_param.sv
// tb_iob_eth_rx_param: directed bench for iob_eth_rx_param.
// Two instances: an MII receiver (DATA_W=4, ADDR_W=11) and a GMII receiver
// with a small buffer (DATA_W=8, ADDR_W=7). Frames and FCS are built here.
module tb_iob_eth_rx_param;

    localparam int          A4   = 11;
    localparam int          A8   = 7;
    localparam logic [47:0] MAC4 = 48'h000102030405;
    localparam logic [47:0] MAC8 = 48'h020000000099;

    logic RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    logic          rst4, dv4, er4, ack4;
    logic [3:0]    data4;
    logic          wr4, fr4, crc_err4, drop4;
    logic [A4-1:0] addr4;
    logic [7:0]    wdata4;
    logic [A4:0]   len4;

    logic          rst8, dv8, er8, ack8;
    logic [7:0]    data8;
    logic          wr8, fr8, crc_err8, drop8;
    logic [A8-1:0] addr8;
    logic [7:0]    wdata8;
    logic [A8:0]   len8;

    iob_eth_rx_param #(.DATA_W(4), .ADDR_W(A4), .MAC_ADDR(MAC4)) dut4 (
        .RX_CLK(RX_CLK), .rst(rst4), .RX_DV(dv4), .RX_ER(er4), .RX_DATA(data4),
        .rx_wr(wr4), .rx_addr(addr4), .rx_wdata(wdata4),
        .frame_received(fr4), .rx_len(len4), .frame_ack(ack4),
        .crc_err(crc_err4), .frame_dropped(drop4)
    );

    iob_eth_rx_param #(.DATA_W(8), .ADDR_W(A8), .MAC_ADDR(MAC8)) dut8 (
        .RX_CLK(RX_CLK), .rst(rst8), .RX_DV(dv8), .RX_ER(er8), .RX_DATA(data8),
        .rx_wr(wr8), .rx_addr(addr8), .rx_wdata(wdata8),
        .frame_received(fr8), .rx_len(len8), .frame_ack(ack8),
        .crc_err(crc_err8), .frame_dropped(drop8)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] frm [0:255];
    int         frm_len = 0;

    // Cumulative monitor counters; tests look at deltas from a snapshot.
    int wr_cnt4 = 0, addr_err4 = 0, data_err4 = 0, crc_cyc4 = 0, drop_cyc4 = 0, base4 = 0;
    int wr_cnt8 = 0, addr_err8 = 0, data_err8 = 0, crc_cyc8 = 0, drop_cyc8 = 0, base8 = 0;
    int s_wr, s_ae, s_de, s_crc, s_drop;
    logic [31:0] rst_snap4;

    always @(negedge RX_CLK) begin
        if (wr4) begin
            if (32'(addr4) != wr_cnt4 - base4) addr_err4++;
            if (wdata4 != frm[addr4]) data_err4++;
            wr_cnt4++;
        end
        if (crc_err4) crc_cyc4++;
        if (drop4) drop_cyc4++;
    end

    always @(negedge RX_CLK) begin
        if (wr8) begin
            if (32'(addr8) != wr_cnt8 - base8) addr_err8++;
            if (wdata8 != frm[addr8]) data_err8++;
            wr_cnt8++;
        end
        if (crc_err8) crc_cyc8++;
        if (drop8) drop_cyc8++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Standard Ethernet FCS, computed one bit at a time.
    function automatic logic [31:0] calc_fcs(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dest, input int total);
        logic [47:0] src;
        logic [31:0] f;
        src = 48'h020000000001;
        for (int i = 0; i < 6; i++) begin
            frm[i]   = dest[47-8*i -: 8];
            frm[i+6] = src[47-8*i -: 8];
        end
        for (int i = 12; i < total - 4; i++) frm[i] = 8'(i * 7 + 3);
        f = calc_fcs(total - 4);
        frm[total-4] = f[7:0];
        frm[total-3] = f[15:8];
        frm[total-2] = f[23:16];
        frm[total-1] = f[31:24];
        frm_len = total;
    endtask

    // Every drive task leaves time at 1 unit after the rising edge that sampled it.
    task automatic drive4(input logic [3:0] n, input logic dv, input logic er, input logic r);
        data4 = n; dv4 = dv; er4 = er; rst4 = r;
        @(posedge RX_CLK); #1;
    endtask

    task automatic drive8(input logic [7:0] n, input logic dv, input logic er);
        data8 = n; dv8 = dv; er8 = er;
        @(posedge RX_CLK); #1;
    endtask

    task automatic send4(input int er_at, input int rst_at);
        base4 = wr_cnt4;
        for (int i = 0; i < 15; i++) drive4(4'h5, 1'b1, 1'b0, 1'b0);
        drive4(4'hD, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < frm_len; i++) begin
            drive4(frm[i][3:0], 1'b1, i == er_at, i == rst_at);
            if (i == rst_at) rst_snap4 = {wr4, fr4, crc_err4, drop4, addr4, wdata4, len4};
            drive4(frm[i][7:4], 1'b1, 1'b0, 1'b0);
        end
        repeat (12) drive4(4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send8();
        base8 = wr_cnt8;
        for (int i = 0; i < 7; i++) drive8(8'h55, 1'b1, 1'b0);
        drive8(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm_len; i++) drive8(frm[i], 1'b1, 1'b0);
        repeat (12) drive8(8'h00, 1'b0, 1'b0);
    endtask

    task automatic snap4();
        s_wr = wr_cnt4; s_ae = addr_err4; s_de = data_err4; s_crc = crc_cyc4; s_drop = drop_cyc4;
    endtask

    task automatic snap8();
        s_wr = wr_cnt8; s_ae = addr_err8; s_de = data_err8; s_crc = crc_cyc8; s_drop = drop_cyc8;
    endtask

    task automatic ack_pulse4(input string name);
        tests++;
        if (fr4 !== 1'b1) begin fails++; $display("FAIL %s_before_ack: frame_received=%b want 1", name, fr4); end
        ack4 = 1'b1;
        @(posedge RX_CLK); #1;
        ack4 = 1'b0;
        tests++;
        if (fr4 !== 1'b0) begin fails++; $display("FAIL %s_after_ack: frame_received=%b want 0", name, fr4); end
        repeat (2) begin @(posedge RX_CLK); #1; end
    endtask

    task automatic ack_pulse8(input string name);
        tests++;
        if (fr8 !== 1'b1) begin fails++; $display("FAIL %s_before_ack: frame_received=%b want 1", name, fr8); end
        ack8 = 1'b1;
        @(posedge RX_CLK); #1;
        ack8 = 1'b0;
        tests++;
        if (fr8 !== 1'b0) begin fails++; $display("FAIL %s_after_ack: frame_received=%b want 0", name, fr8); end
        repeat (2) begin @(posedge RX_CLK); #1; end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1; dv4 = 1'b0; dv8 = 1'b0; er4 = 1'b0; er8 = 1'b0;
        data4 = 4'h0; data8 = 8'h00; ack4 = 1'b0; ack8 = 1'b0;
        repeat (3) begin @(posedge RX_CLK); #1; end
        tests++;
        if ({wr4, fr4, crc_err4, drop4, addr4, wdata4, len4} !== '0) begin
            fails++; $display("FAIL reset_mii: outputs=%h want 0", {wr4, fr4, crc_err4, drop4, addr4, wdata4, len4});
        end
        tests++;
        if ({wr8, fr8, crc_err8, drop8, addr8, wdata8, len8} !== '0) begin
            fails++; $display("FAIL reset_gmii: outputs=%h want 0", {wr8, fr8, crc_err8, drop8, addr8, wdata8, len8});
        end
        rst4 = 1'b0; rst8 = 1'b0;
        repeat (3) begin @(posedge RX_CLK); #1; end
    endtask

    task automatic test_unicast_mii();
        build_frame(MAC4, 64);
        snap4();
        send4(-1, -1);
        tests++;
        if (wr_cnt4 - s_wr != 64) begin fails++; $display("FAIL uni_writes: got %0d want 64", wr_cnt4 - s_wr); end
        tests++;
        if ((addr_err4 - s_ae) + (data_err4 - s_de) != 0) begin
            fails++; $display("FAIL uni_contents: addr errors %0d data errors %0d want 0", addr_err4 - s_ae, data_err4 - s_de);
        end
        tests++;
        if (len4 !== 12'd64) begin fails++; $display("FAIL uni_len: got %0d want 64", len4); end
        tests++;
        if (crc_cyc4 - s_crc != 0) begin fails++; $display("FAIL uni_crc_err: got %0d cycles want 0", crc_cyc4 - s_crc); end
        ack_pulse4("uni");
    endtask

    task automatic test_broadcast_gmii();
        build_frame(48'hFFFFFFFFFFFF, 100);
        snap8();
        send8();
        tests++;
        if (wr_cnt8 - s_wr != 100) begin fails++; $display("FAIL bc_writes: got %0d want 100", wr_cnt8 - s_wr); end
        tests++;
        if ((addr_err8 - s_ae) + (data_err8 - s_de) != 0) begin
            fails++; $display("FAIL bc_contents: addr errors %0d data errors %0d want 0", addr_err8 - s_ae, data_err8 - s_de);
        end
        tests++;
        if (len8 !== 8'd100) begin fails++; $display("FAIL bc_len: got %0d want 100", len8); end
        ack_pulse8("bc");
    endtask

    task automatic test_mac_reject();
        build_frame(48'h0A0B0C0D0E0F, 64);
        snap4();
        send4(-1, -1);
        tests++;
        if (wr_cnt4 - s_wr != 6) begin fails++; $display("FAIL reject_writes: got %0d want 6", wr_cnt4 - s_wr); end
        tests++;
        if ({fr4, 32'(crc_cyc4 - s_crc), 32'(drop_cyc4 - s_drop)} !== '0) begin
            fails++; $display("FAIL reject_quiet: frame_received=%b crc_err=%0d dropped=%0d want 0", fr4, crc_cyc4 - s_crc, drop_cyc4 - s_drop);
        end
        build_frame(MAC4, 70);
        send4(-1, -1);
        tests++;
        if (len4 !== 12'd70) begin fails++; $display("FAIL reject_next_len: got %0d want 70", len4); end
        ack_pulse4("reject_next");
    endtask

    task automatic test_bad_fcs();
        build_frame(MAC4, 64);
        frm[63] = frm[63] ^ 8'hFF;
        snap4();
        send4(-1, -1);
        tests++;
        if (crc_cyc4 - s_crc != 1) begin fails++; $display("FAIL badfcs_pulse: crc_err high %0d cycles want 1", crc_cyc4 - s_crc); end
        tests++;
        if (fr4 !== 1'b0) begin fails++; $display("FAIL badfcs_received: got %b want 0", fr4); end
    endtask

    task automatic test_rx_er();
        build_frame(MAC4, 64);
        snap4();
        send4(20, -1);
        tests++;
        if (drop_cyc4 - s_drop != 1) begin fails++; $display("FAIL rxer_pulse: frame_dropped high %0d cycles want 1", drop_cyc4 - s_drop); end
        tests++;
        if (wr_cnt4 - s_wr != 20) begin fails++; $display("FAIL rxer_writes: got %0d want 20", wr_cnt4 - s_wr); end
        tests++;
        if ({fr4, 32'(crc_cyc4 - s_crc)} !== '0) begin
            fails++; $display("FAIL rxer_quiet: frame_received=%b crc_err=%0d want 0", fr4, crc_cyc4 - s_crc);
        end
    endtask

    task automatic test_overflow();
        build_frame(48'hFFFFFFFFFFFF, 200);
        snap8();
        send8();
        tests++;
        if (wr_cnt8 - s_wr != 128) begin fails++; $display("FAIL ovf_writes: got %0d want 128", wr_cnt8 - s_wr); end
        tests++;
        if (addr_err8 - s_ae != 0) begin fails++; $display("FAIL ovf_addr: %0d address errors want 0", addr_err8 - s_ae); end
        tests++;
        if (drop_cyc8 - s_drop != 1) begin fails++; $display("FAIL ovf_pulse: frame_dropped high %0d cycles want 1", drop_cyc8 - s_drop); end
        tests++;
        if (fr8 !== 1'b0) begin fails++; $display("FAIL ovf_received: got %b want 0", fr8); end
    endtask

    task automatic test_rst_mid_frame();
        build_frame(MAC4, 64);
        snap4();
        send4(-1, 30);
        tests++;
        if (rst_snap4 !== 32'h0) begin fails++; $display("FAIL rstmid_outputs: got %h want 0", rst_snap4); end
        tests++;
        if (wr_cnt4 - s_wr != 30) begin fails++; $display("FAIL rstmid_writes: got %0d want 30", wr_cnt4 - s_wr); end
        tests++;
        if ({fr4, 32'(crc_cyc4 - s_crc), 32'(drop_cyc4 - s_drop)} !== '0) begin
            fails++; $display("FAIL rstmid_quiet: frame_received=%b crc_err=%0d dropped=%0d want 0", fr4, crc_cyc4 - s_crc, drop_cyc4 - s_drop);
        end
        build_frame(MAC4, 80);
        send4(-1, -1);
        tests++;
        if (len4 !== 12'd80) begin fails++; $display("FAIL rstmid_next_len: got %0d want 80", len4); end
        ack_pulse4("rstmid_next");
    endtask

    task automatic test_hold_busy();
        build_frame(MAC8, 64);
        send8();
        tests++;
        if (len8 !== 8'd64) begin fails++; $display("FAIL busy_first_len: got %0d want 64", len8); end
        build_frame(MAC8, 70);
        snap8();
        send8();
        tests++;
        if (drop_cyc8 - s_drop != 1) begin fails++; $display("FAIL busy_pulse: frame_dropped high %0d cycles want 1", drop_cyc8 - s_drop); end
        tests++;
        if (wr_cnt8 - s_wr != 0) begin fails++; $display("FAIL busy_writes: got %0d want 0", wr_cnt8 - s_wr); end
        tests++;
        if (len8 !== 8'd64) begin fails++; $display("FAIL busy_len_kept: got %0d want 64", len8); end
        ack_pulse8("busy");
    endtask

    task automatic test_runt();
        build_frame(MAC8, 40);
        snap8();
        send8();
        tests++;
        if (wr_cnt8 - s_wr != 40) begin fails++; $display("FAIL runt_writes: got %0d want 40", wr_cnt8 - s_wr); end
        tests++;
        if ({fr8, 32'(crc_cyc8 - s_crc), 32'(drop_cyc8 - s_drop)} !== '0) begin
            fails++; $display("FAIL runt_quiet: frame_received=%b crc_err=%0d dropped=%0d want 0", fr8, crc_cyc8 - s_crc, drop_cyc8 - s_drop);
        end
    endtask

    initial begin
        test_reset();
        test_unicast_mii();
        test_broadcast_gmii();
        test_mac_reject();
        test_bad_fcs();
        test_rx_er();
        test_overflow();
        test_rst_mid_frame();
        test_hold_busy();
        test_runt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iob_eth_rx_param.md
Name: iob_eth_rx_param

Overview:
Parametrised Ethernet MII/GMII receive engine for the iob_eth core.
- Hunts preamble/SFD, assembles bytes, and filters on destination MAC (unicast or broadcast).
- Writes the frame into the RX buffer RAM and checks FCS with an internal CRC-32.
- Raises a held frame-ready flag with byte length for the host-side DMA/CPU, and waits for acknowledge before accepting the next frame.
- Successor to the fixed 4-bit receiver: configurable lane width, buffer depth and station address; adds error/drop reporting and an overflow guard.

Parameters:
DATA_W, 4, PHY data lane width; 4 = MII (low nibble first), 8 = GMII; other values illegal
ADDR_W, 11, RX buffer byte-address width; max frame 2**ADDR_W bytes
MAC_ADDR, 48'h000000000000, station MAC address accepted as unicast destination

Ports:
RX_CLK  in  1  PHY receive clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
RX_DV  in  1  PHY data valid
RX_ER  in  1  PHY receive error
RX_DATA  in  DATA_W  PHY receive data
rx_wr  out  1  buffer write strobe, one per stored byte
rx_addr  out  ADDR_W  buffer byte address; byte 0 = first destination-MAC byte
rx_wdata  out  8  buffer write data
frame_received  out  1  level; good frame in buffer, held until frame_ack
rx_len  out  ADDR_W+1  byte count of held frame, including 4 FCS bytes; valid while frame_received
frame_ack  in  1  host releases buffer; sampled only while frame_received
crc_err  out  1  one-cycle pulse: frame ended with bad FCS
frame_dropped  out  1  one-cycle pulse: frame discarded for RX_ER, overflow, or buffer busy

Behaviour:
- Reset values: all outputs 0; state = WAIT_IDLE.
- States: WAIT_IDLE, HUNT, DATA, CHECK, HOLD.
- WAIT_IDLE: stay until RX_DV=0, then go to HUNT. Entered after reset so a frame already in progress is never captured mid-frame.
- HUNT, preamble/SFD detection (RX_DV=1):
  - DATA_W=4: lane 4'h5 counts as preamble; 4'hD after at least one 4'h5 is SFD.
  - DATA_W=8: 8'h55 counts as preamble; 8'hD5 is SFD.
  - Any other value -> WAIT_IDLE.
  - On SFD: go to DATA; clear byte counter; seed CRC to 32'hFFFFFFFF.
- DATA, byte assembly:
  - DATA_W=4: two lane cycles per byte, low nibble first.
  - DATA_W=8: one byte per cycle.
  - Each completed byte: rx_wr=1 for one cycle with rx_addr = counter and rx_wdata = byte; CRC updated with byte; counter increments.
  - Write is registered: rx_wr asserts the cycle after the completing lane sample.
- MAC filter:
  - Bytes 0-5 compared against MAC_ADDR, MSB byte first.
  - After byte 5: if destination is neither MAC_ADDR nor 48'hFFFFFFFFFFFF -> WAIT_IDLE, no pulse.
  - Bytes 0-5 are still written to the buffer before the decision.
- RX_ER=1 in DATA: pulse frame_dropped, -> WAIT_IDLE.
- Overflow: a byte completing when counter = 2**ADDR_W is not written; pulse frame_dropped, -> WAIT_IDLE.
- RX_DV falling in DATA:
  - A half byte (odd nibble count) is discarded.
  - If counter < 64: silent -> HUNT (runt frame).
  - Otherwise -> CHECK.
- CHECK (one cycle):
  - CRC register == residue 32'hC704DD7B -> HOLD; frame_received=1; rx_len = counter.
  - Otherwise pulse crc_err -> HUNT.
- HOLD:
  - frame_received, rx_len stable; rx_wr never asserted.
  - An SFD seen in HOLD pulses frame_dropped once for that frame.
  - frame_ack=1 -> frame_received=0 next cycle; go to HUNT if RX_DV=0, else WAIT_IDLE.
- frame_ack outside HOLD: ignored.
- rst mid-frame: outputs cleared next edge, partial frame abandoned without pulse, -> WAIT_IDLE.
- CRC-32: reflected polynomial 32'hEDB88320, byte-wise, LSB first.
- Counter: ADDR_W+1 bits; no wrap beyond the overflow guard.

Optional Feature:
Macro IOB_ETH_RX_PROMISC_EN.
- Defined: extra input port promisc (1 bit). When promisc=1, the MAC filter is bypassed and all frames are accepted; when 0, the filter is normal.
- Undefined: port absent; filter always active.

Test Plan:
1. MAC_ADDR=48'h0102030405, DATA_W=4: 7x 0x55 + 0xD5, 60-byte unicast payload + valid FCS -> 64 rx_wr at addr 0..63; frame_received=1; rx_len=64; crc_err=0.
2. DATA_W=8, broadcast destination 48'hFFFFFFFFFFFF, 100 bytes incl. FCS -> rx_len=100; then frame_ack -> frame_received=0 one cycle later.
3. Destination 48'h0A0B0C0D0E0F -> exactly 6 writes, no frame_received, no pulses; next valid frame accepted normally.
4. Valid frame with last FCS byte flipped -> crc_err one-cycle pulse, frame_received stays 0. Repeat with RX_ER raised at byte 20 -> frame_dropped pulse.
5. ADDR_W=7, 200-byte frame -> 128 writes, frame_dropped at byte 129, nothing further written.
6. rst asserted at byte 30 while RX_DV stays high -> outputs 0; remainder ignored; a new frame after an RX_DV=0 gap is received. Also: second frame arriving in HOLD -> frame_dropped, first rx_len unchanged.
